// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite encodings used by in-house bus agents.
// Contents: HTRANS, HBURST, HSIZE and HRESP constants.
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_simple_master_if.sv
// ---------------------------------------------------------------------------
// ahb3lite_simple_master_if
// Bundles the command/response stream and the AHB3-Lite bus of the simple
// initiator.
//   master modport : the initiator's view (drives cmd_ready, rsp_*, H* outputs)
//   slave modport  : the environment's view (drives cmd_*, HRDATA/HREADY/HRESP)
// ---------------------------------------------------------------------------
interface ahb3lite_simple_master_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    // command stream
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [HADDR_SIZE-1:0] cmd_addr;
    logic [2:0]            cmd_size;
    logic [HDATA_SIZE-1:0] cmd_wdata;

    // response stream
    logic                  rsp_valid;
    logic [HDATA_SIZE-1:0] rsp_rdata;
    logic                  rsp_err;

    // AHB3-Lite bus
    logic [HADDR_SIZE-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb3lite_simple_master.sv
// ---------------------------------------------------------------------------
// ahb3lite_simple_master
// Turns a valid/ready command stream into single NONSEQ AHB3-Lite transfers
// with address/data pipelining, wait-state support and two-cycle ERROR
// handling. One in-order response is returned per accepted command.
// Ports:
//   HCLK   : clock, rising edge
//   HRESET : asynchronous active-high reset
//   bus    : ahb3lite_simple_master_if.master (command, response, AHB bus)
// ---------------------------------------------------------------------------
module ahb3lite_simple_master
    import ahb3lite_pkg::*;
#(
    parameter int         HADDR_SIZE = 32,
    parameter int         HDATA_SIZE = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    ahb3lite_simple_master_if.master  bus
);

    // address-phase stage
    logic                  a_vld_q,   a_vld_d;
    logic                  a_we_q,    a_we_d;
    logic [HADDR_SIZE-1:0] a_addr_q,  a_addr_d;
    logic [2:0]            a_size_q,  a_size_d;
    logic [HDATA_SIZE-1:0] a_wdata_q, a_wdata_d;

    // data-phase stage
    logic                  d_vld_q,   d_vld_d;
    logic                  d_we_q,    d_we_d;
    logic [HDATA_SIZE-1:0] hwdata_q,  hwdata_d;

    // set between the two ERROR cycles to force HTRANS to IDLE
    logic                  kill_q,    kill_d;

    // response
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

    logic cmd_ready;
    logic accept;
    logic a_done;
    logic d_done;

    // Handshake and phase-completion terms. A new command may enter only when
    // the address stage is empty or is handing over this cycle; a killed
    // address phase holds its command until the error sequence finishes.
    always_comb begin
        a_done    = a_vld_q & ~kill_q & bus.HREADY;
        d_done    = d_vld_q & bus.HREADY;
        cmd_ready = ~HRESET & ~kill_q & (~a_vld_q | bus.HREADY);
        accept    = bus.cmd_valid & cmd_ready;
    end

    // Next-state logic for both pipeline stages, the kill flag and the
    // response registers.
    always_comb begin
        a_vld_d     = a_vld_q;
        a_we_d      = a_we_q;
        a_addr_d    = a_addr_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        d_vld_d     = d_vld_q;
        d_we_d      = d_we_q;
        hwdata_d    = hwdata_q;
        kill_d      = kill_q;
        rsp_valid_d = d_done;
        rsp_err_d   = d_done & (bus.HRESP == HRESP_ERROR);
        rsp_rdata_d = (d_done & ~d_we_q) ? bus.HRDATA : '0;

        if (accept) begin
            a_vld_d   = 1'b1;
            a_we_d    = bus.cmd_we;
            a_addr_d  = bus.cmd_addr;
            a_size_d  = bus.cmd_size;
            a_wdata_d = bus.cmd_wdata;
        end else if (a_done) begin
            a_vld_d   = 1'b0;
        end

        if (a_done) begin
            d_vld_d  = 1'b1;
            d_we_d   = a_we_q;
            hwdata_d = a_wdata_q;
        end else if (d_done) begin
            d_vld_d  = 1'b0;
        end

        // First ERROR cycle (HREADY low) raises kill; the closing HREADY
        // cycle of the error response drops it again.
        if (d_vld_q & (bus.HRESP == HRESP_ERROR) & ~bus.HREADY) begin
            kill_d = 1'b1;
        end else if (kill_q & bus.HREADY) begin
            kill_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_vld_q     <= 1'b0;
            a_we_q      <= 1'b0;
            a_addr_q    <= '0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_we_q      <= 1'b0;
            hwdata_q    <= '0;
            kill_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_vld_q     <= a_vld_d;
            a_we_q      <= a_we_d;
            a_addr_q    <= a_addr_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_we_q      <= d_we_d;
            hwdata_q    <= hwdata_d;
            kill_q      <= kill_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus outputs straight from the stage registers; HTRANS is a pure
    // function of two flops so reset idles the bus immediately.
    assign bus.HTRANS    = (a_vld_q & ~kill_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = a_addr_q;
    assign bus.HWRITE    = a_we_q;
    assign bus.HSIZE     = a_size_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb3lite_simple_master.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_simple_master
// Drives commands into ahb3lite_simple_master, models an AHB slave whose
// per-transfer behaviour (wait states, error, read data) is planned with the
// command, and scores responses and bus activity against that plan.
// ---------------------------------------------------------------------------
module tb_ahb3lite_simple_master;
    import ahb3lite_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        bit          err2;
        logic [31:0] rdata;
        int          gap;
    } cmd_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    logic HCLK;
    logic HRESET;

    ahb3lite_simple_master_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

    ahb3lite_simple_master #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .HPROT_VAL (4'b0011)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    int   nChecks;
    int   nFails;
    int   cyc;

    cmd_t stimQ[$];
    cmd_t busQ[$];
    rsp_t expQ[$];

    cmd_t cur;
    bit   curValid;
    int   gapCnt;
    cmd_t dp;
    bit   dpActive;
    int   dpCnt;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Count and report one comparison.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input cmd_t c);
        stimQ.push_back(c);
    endtask

    function automatic cmd_t mk(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input int waits, input bit err,
                                input bit err2, input logic [31:0] rdata, input int gap);
        cmd_t c;
        c.we = we; c.addr = addr; c.size = size; c.wdata = wdata; c.waits = waits;
        c.err = err; c.err2 = err2; c.rdata = rdata; c.gap = gap;
        return c;
    endfunction

    function automatic cmd_t randCmd();
        logic [2:0] sizes [3];
        logic [2:0] sz;
        sizes[0] = HSIZE_BYTE; sizes[1] = HSIZE_HWORD; sizes[2] = HSIZE_WORD;
        sz = sizes[$urandom_range(0, 2)];
        return mk($urandom_range(0, 1) == 1, $urandom & ~((32'd1 << sz) - 32'd1), sz, $urandom,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    endfunction

    // Wait (bounded) until every issued command has been answered.
    task automatic drain();
        int n = 0;
        while ((stimQ.size() != 0 || curValid || expQ.size() != 0) && n < 3000) begin
            @(negedge HCLK);
            n++;
        end
        checkOutput("drain_pending", 32'(stimQ.size() + expQ.size() + int'(curValid)), 32'd0);
        repeat (2) @(negedge HCLK);
    endtask

    // Driver and slave model: drive at the falling edge, sample just before
    // the rising edge what the DUT is about to register.
    initial begin : busProc
        cmd_t c;
        rsp_t e;
        bit   accepted;
        curValid = 0; gapCnt = 0; dpActive = 0; dpCnt = 0;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0;
        bus.cmd_size = '0; bus.cmd_wdata = '0;
        bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY; bus.HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                curValid = 0; gapCnt = 0; dpActive = 0;
                busQ.delete();
                bus.cmd_valid = 1'b0; bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY;
                continue;
            end
            if (!curValid && stimQ.size() > 0) begin
                if (gapCnt < stimQ[0].gap) gapCnt++;
                else begin
                    cur = stimQ.pop_front();
                    curValid = 1;
                    gapCnt = 0;
                end
            end
            bus.cmd_valid = curValid;
            bus.cmd_we    = curValid ? cur.we    : 1'($urandom);
            bus.cmd_addr  = curValid ? cur.addr  : $urandom;
            bus.cmd_size  = curValid ? cur.size  : 3'($urandom);
            bus.cmd_wdata = curValid ? cur.wdata : $urandom;
            if (dpActive && dpCnt < dp.waits) begin
                bus.HREADY = 1'b0; bus.HRESP = HRESP_OKAY; bus.HRDATA = $urandom;
            end else if (dpActive && dp.err && dp.err2 && dpCnt == dp.waits) begin
                bus.HREADY = 1'b0; bus.HRESP = HRESP_ERROR; bus.HRDATA = $urandom;
            end else if (dpActive) begin
                bus.HREADY = 1'b1; bus.HRESP = dp.err ? HRESP_ERROR : HRESP_OKAY;
                bus.HRDATA = dp.we ? $urandom : dp.rdata;
            end else begin
                bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY; bus.HRDATA = $urandom;
            end
            #4;
            if (HRESET) continue;
            accepted = bus.cmd_valid && bus.cmd_ready;
            if (!bus.HREADY && bus.HTRANS == HTRANS_NONSEQ)
                checkOutput("cmd_ready_stall", 32'(bus.cmd_ready), 32'd0);
            if (dpActive && dp.err && dp.err2 && dpCnt == dp.waits + 1)
                checkOutput("htrans_idle_err2", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            if (dpActive) begin
                if (bus.HREADY) begin
                    if (dp.we) checkOutput("hwdata", bus.HWDATA, dp.wdata);
                    dpActive = 0;
                end else begin
                    dpCnt++;
                end
            end
            if (bus.HTRANS == HTRANS_NONSEQ && bus.HREADY) begin
                if (busQ.size() == 0) begin
                    checkOutput("spurious_nonseq", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
                end else begin
                    c = busQ.pop_front();
                    checkOutput("haddr",  bus.HADDR, c.addr);
                    checkOutput("hwrite", 32'(bus.HWRITE), 32'(c.we));
                    checkOutput("hsize",  32'(bus.HSIZE), 32'(c.size));
                    dp = c; dpActive = 1; dpCnt = 0;
                end
            end
            if (accepted) begin
                e.err   = cur.err;
                e.rdata = cur.we ? 32'd0 : cur.rdata;
                // Latency is only predictable from an empty pipeline.
                e.cyc   = (expQ.size() == 0) ? cyc + 3 + cur.waits + int'(cur.err && cur.err2) : -1;
                expQ.push_back(e);
                busQ.push_back(cur);
                curValid = 0;
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT strobes one.
    initial begin : monProc
        rsp_t e;
        forever begin
            @(negedge HCLK);
            if (bus.rsp_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("rsp_without_cmd", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_err",   32'(bus.rsp_err), 32'(e.err));
                    checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
                    if (e.cyc >= 0) checkOutput("rsp_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainProc
        int n;
        nChecks = 0; nFails = 0; cyc = 0;
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        #1;
        checkOutput("reset_htrans",    32'(bus.HTRANS), 32'(HTRANS_IDLE));
        checkOutput("reset_haddr",     bus.HADDR, 32'd0);
        checkOutput("reset_hwrite",    32'(bus.HWRITE), 32'd0);
        checkOutput("reset_hsize",     32'(bus.HSIZE), 32'd0);
        checkOutput("reset_hwdata",    bus.HWDATA, 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("hburst",          32'(bus.HBURST), 32'(HBURST_SINGLE));
        checkOutput("hprot",           32'(bus.HPROT), 32'h3);
        checkOutput("hmastlock",       32'(bus.HMASTLOCK), 32'd0);
        @(negedge HCLK);
        #2 HRESET = 1'b0;

        $display("[TB] zero-wait write");
        applyStimulus(mk(1'b1, 32'h0000_2000, HSIZE_WORD, 32'h5, 0, 0, 0, 32'h0, 0));
        drain();

        $display("[TB] read with two wait states");
        applyStimulus(mk(1'b0, 32'h0020_0004, HSIZE_WORD, 32'h0, 2, 0, 0, 32'h7, 0));
        drain();

        $display("[TB] back-to-back writes");
        for (int i = 0; i < 3; i++)
            applyStimulus(mk(1'b1, 32'h100 + 32'(4 * i), HSIZE_WORD, 32'hA0 + 32'(i), 0, 0, 0, 32'h0, 0));
        drain();

        $display("[TB] two-cycle error with pipelined read");
        applyStimulus(mk(1'b1, 32'h0000_3000, HSIZE_WORD, 32'hDEAD_BEEF, 0, 1, 1, 32'h0, 0));
        applyStimulus(mk(1'b0, 32'h0000_3004, HSIZE_WORD, 32'h0, 0, 0, 0, 32'h1234_5678, 0));
        drain();

        $display("[TB] single-cycle error");
        applyStimulus(mk(1'b1, 32'h0000_4000, HSIZE_WORD, 32'h11, 0, 1, 0, 32'h0, 0));
        applyStimulus(mk(1'b0, 32'h0000_4004, HSIZE_HWORD, 32'h0, 0, 0, 0, 32'h0000_BEEF, 0));
        drain();

        $display("[TB] backpressure");
        applyStimulus(mk(1'b0, 32'h0000_5000, HSIZE_WORD, 32'h0, 4, 0, 0, 32'hCAFE_0001, 0));
        applyStimulus(mk(1'b1, 32'h0000_5004, HSIZE_WORD, 32'h22, 0, 0, 0, 32'h0, 0));
        applyStimulus(mk(1'b0, 32'h0000_5008, HSIZE_BYTE, 32'h0, 1, 0, 0, 32'h0000_0033, 0));
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) applyStimulus(randCmd());
        drain();

        $display("[TB] reset during read data phase");
        applyStimulus(mk(1'b0, 32'h0000_6000, HSIZE_WORD, 32'h0, 5, 0, 0, 32'h99, 0));
        applyStimulus(mk(1'b1, 32'h0000_6004, HSIZE_WORD, 32'h77, 0, 0, 0, 32'h0, 0));
        n = 0;
        while (n < 50) begin
            @(negedge HCLK);
            #2;
            if (dpActive && !dp.we && bus.HTRANS == HTRANS_NONSEQ) break;
            n++;
        end
        checkOutput("reset_setup", 32'(dpActive), 32'd1);
        HRESET = 1'b1;
        expQ.delete();
        stimQ.delete();
        #1;
        checkOutput("midreset_htrans",    32'(bus.HTRANS), 32'(HTRANS_IDLE));
        checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (3) @(negedge HCLK);
        #2 HRESET = 1'b0;
        repeat (5) @(negedge HCLK);

        $display("[TB] traffic after reset");
        applyStimulus(mk(1'b0, 32'h0000_7000, HSIZE_WORD, 32'h0, 0, 0, 0, 32'h0BAD_F00D, 0));
        for (int i = 0; i < 20; i++) applyStimulus(randCmd());
        drain();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
